// File: rtl/cfg_loader_pkg.sv
// -----------------------------------------------------------------------------
// cfg_loader_pkg : shared types, constants and helpers for cfg_loader_burst.
// Revision: 1.0 - initial release
// -----------------------------------------------------------------------------
`default_nettype none

package cfg_loader_pkg;

  // Loader FSM states
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  // CRC-8 generator polynomial x^8 + x^2 + x + 1
  localparam logic [7:0] CRC8_POLY = 8'h07;

  // Widest one-hot vector the decode helper can produce
  localparam int unsigned MAX_ONEHOT_W = 32;

  // One-hot decode of idx into nb bits; out-of-range indices give all zeros
  function automatic logic [MAX_ONEHOT_W-1:0] onehot_decode(input logic [31:0] idx,
                                                            input logic [31:0] nb);
    logic [MAX_ONEHOT_W-1:0] oh;
    oh = '0;
    for (int i = 0; i < MAX_ONEHOT_W; i++) begin
      if ((32'(i) < nb) && (32'(i) == idx)) oh[i] = 1'b1;
    end
    return oh;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cfg_loader_crc8.sv
// -----------------------------------------------------------------------------
// cfg_loader_crc8 : running CRC-8 (poly 0x07, init 0x00) over written data
//                   words, MSB first. Only built when LOADER_CRC_EN is defined.
// Revision: 1.0 - initial release
// -----------------------------------------------------------------------------
`default_nettype none

module cfg_loader_crc8
  import cfg_loader_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,  // restart the CRC (burst start)
  input  logic              upd_i,    // a data word is being written
  input  logic [DATA_W-1:0] data_i,
  output logic [7:0]        crc_o
);

  logic [7:0] crc_q;
  logic [7:0] crc_d;
  logic [7:0] base_w;
  logic       fb_w;

  // Next CRC: a clear restarts from zero before folding in the new word
  always_comb begin
    base_w = clear_i ? 8'h00 : crc_q;
    crc_d  = base_w;
    fb_w   = 1'b0;
    if (upd_i) begin
      for (int i = DATA_W - 1; i >= 0; i--) begin
        fb_w  = crc_d[7] ^ data_i[i];
        crc_d = {crc_d[6:0], 1'b0} ^ (fb_w ? CRC8_POLY : 8'h00);
      end
    end
  end

  // CRC register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) crc_q <= 8'h00;
    else         crc_q <= crc_d;
  end

  assign crc_o = crc_q;

endmodule

`default_nettype wire

// File: rtl/cfg_loader_burst.sv
// -----------------------------------------------------------------------------
// cfg_loader_burst : tile configuration loader with valid/ready handshake,
//                    auto-incrementing bursts, sticky ERROR and DONE pulse.
//                    Optional CRC output when LOADER_CRC_EN is defined.
// Revision: 1.0 - initial release
// -----------------------------------------------------------------------------
`default_nettype none

module cfg_loader_burst
  import cfg_loader_pkg::*;
#(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned SUB_ADDR_W = 9,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned NB_ELEM    = 2,
  parameter int unsigned LEN_W      = 8
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  SELECT,
  input  logic                  VALID,
  output logic                  READY,
  input  logic                  MODE,
  input  logic [ADDR_W-1:0]     ADDRESS,
  input  logic [LEN_W-1:0]      BURST_LEN,
  input  logic [DATA_W-1:0]     DATA_IN,
  input  logic                  CLEAR_ERR,
  output logic [SUB_ADDR_W-1:0] ADDRESS_SB_OR_CLUSTER,
  output logic [DATA_W-1:0]     DATA_OUT,
  output logic [NB_ELEM-1:0]    SELECT_SB_OR_CLUSTER,
  output logic                  DONE,
  output logic                  ERROR
`ifdef LOADER_CRC_EN
  ,
  output logic [7:0]            CRC
`endif
);

  localparam int unsigned IDX_W  = ADDR_W - SUB_ADDR_W;
  localparam int unsigned IDX_P1 = IDX_W + 1;
  localparam int unsigned SUB_P1 = SUB_ADDR_W + 1;
  localparam logic [IDX_W:0] NB_LIM = IDX_P1'(NB_ELEM);

  if ((SUB_ADDR_W >= ADDR_W) || (NB_ELEM < 1) || (NB_ELEM > (2 ** IDX_W)) ||
      (NB_ELEM > MAX_ONEHOT_W)) begin : g_bad_params
    $error("cfg_loader_burst: NB_ELEM must be within 1..2**(ADDR_W-SUB_ADDR_W)");
  end

  state_e                state_q, state_d;
  logic                  err_q, done_q;
  logic [NB_ELEM-1:0]    sel_q;
  logic [SUB_ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0]     data_q;
  logic [IDX_W-1:0]      base_idx_q;
  logic [SUB_ADDR_W:0]   sub_cnt_q;   // one spare bit flags an element-boundary crossing
  logic [LEN_W-1:0]      rem_q;       // beats still owed after the current one

  logic                  accept_w, idx_ok_w, ovf_w, last_w, burst_start_w;
  logic [IDX_W-1:0]      idx_in_w;
  logic                  wr_w, done_w, err_set_w;
  logic [SUB_ADDR_W-1:0] wr_sub_w;
  logic [IDX_W-1:0]      wr_idx_w;

  assign accept_w      = VALID & SELECT & ~err_q;
  assign idx_in_w      = ADDRESS[ADDR_W-1:SUB_ADDR_W];
  assign idx_ok_w      = {1'b0, idx_in_w} < NB_LIM;
  assign ovf_w         = sub_cnt_q[SUB_ADDR_W];
  assign last_w        = (rem_q == LEN_W'(1));
  assign burst_start_w = accept_w & MODE & (state_q == IDLE);

  // FSM state register
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state: enter BURST on a valid multi-beat start, leave on last beat or overflow
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (burst_start_w && idx_ok_w && (BURST_LEN != '0)) state_d = BURST;
      BURST:   if (accept_w && (ovf_w || last_w))                  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: what the accepted beat writes, whether it ends a burst or raises an error
  always_comb begin
    wr_w      = 1'b0;
    done_w    = 1'b0;
    err_set_w = 1'b0;
    wr_sub_w  = ADDRESS[SUB_ADDR_W-1:0];
    wr_idx_w  = idx_in_w;
    case (state_q)
      IDLE: begin
        if (accept_w) begin
          if (!idx_ok_w) begin
            err_set_w = 1'b1;
          end else begin
            wr_w   = 1'b1;
            done_w = MODE & (BURST_LEN == '0);
          end
        end
      end
      BURST: begin
        wr_sub_w = sub_cnt_q[SUB_ADDR_W-1:0];
        wr_idx_w = base_idx_q;
        if (accept_w) begin
          if (ovf_w) begin
            err_set_w = 1'b1;
          end else begin
            wr_w   = 1'b1;
            done_w = last_w;
          end
        end
      end
      default: ;
    endcase
  end

  // Output registers: strobe/DONE pulse for one cycle, address/data hold between writes
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      sel_q  <= '0;
      addr_q <= '0;
      data_q <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      sel_q  <= wr_w ? NB_ELEM'(onehot_decode(32'(wr_idx_w), 32'(NB_ELEM))) : '0;
      done_q <= done_w;
      err_q  <= err_set_w | (err_q & ~CLEAR_ERR);
      if (wr_w) begin
        addr_q <= wr_sub_w;
        data_q <= DATA_IN;
      end
    end
  end

  // Burst bookkeeping: latch base/length on the first beat, advance on each write
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      base_idx_q <= '0;
      sub_cnt_q  <= '0;
      rem_q      <= '0;
    end else if (burst_start_w) begin
      base_idx_q <= idx_in_w;
      sub_cnt_q  <= {1'b0, ADDRESS[SUB_ADDR_W-1:0]} + SUB_P1'(1);
      rem_q      <= BURST_LEN;
    end else if (wr_w && (state_q == BURST)) begin
      sub_cnt_q  <= sub_cnt_q + SUB_P1'(1);
      rem_q      <= rem_q - LEN_W'(1);
    end
  end

`ifdef LOADER_CRC_EN
  cfg_loader_crc8 #(
    .DATA_W (DATA_W)
  ) u_crc (
    .clk_i   (CLK),
    .rst_ni  (RESET),
    .clear_i (burst_start_w),
    .upd_i   (wr_w),
    .data_i  (DATA_IN),
    .crc_o   (CRC)
  );
`endif

  assign READY                 = ~err_q;
  assign ERROR                 = err_q;
  assign DONE                  = done_q;
  assign SELECT_SB_OR_CLUSTER  = sel_q;
  assign ADDRESS_SB_OR_CLUSTER = addr_q;
  assign DATA_OUT              = data_q;

endmodule

`default_nettype wire

// File: tb/tb_cfg_loader_burst.sv
// -----------------------------------------------------------------------------
// tb_cfg_loader_burst : scoreboard bench for cfg_loader_burst (default widths)
//                       plus a one-element instance for invalid-index errors.
// Revision: 1.0 - initial release
// -----------------------------------------------------------------------------
`default_nettype none

module tb_cfg_loader_burst;

  localparam int SUB_W = 9;
  localparam int NB    = 2;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic       SELECT = 1'b0, VALID = 1'b0, MODE = 1'b0, CLEAR_ERR = 1'b0, VALID1 = 1'b0;
  logic [9:0] ADDRESS = '0;
  logic [7:0] BURST_LEN = '0, DATA_IN = '0;

  logic       READY, DONE, ERROR;
  logic [8:0] ADDR_O;
  logic [7:0] DATA_O;
  logic [1:0] SEL_O;
  logic       READY1, DONE1, ERROR1;
  logic [8:0] ADDR1;
  logic [7:0] DATA1;
  logic [0:0] SEL1;
`ifdef LOADER_CRC_EN
  logic [7:0] CRC, CRC1;
`endif

  always #5 CLK = ~CLK;

  cfg_loader_burst dut (
    .CLK(CLK), .RESET(RESET), .SELECT(SELECT), .VALID(VALID), .READY(READY),
    .MODE(MODE), .ADDRESS(ADDRESS), .BURST_LEN(BURST_LEN), .DATA_IN(DATA_IN),
    .CLEAR_ERR(CLEAR_ERR), .ADDRESS_SB_OR_CLUSTER(ADDR_O), .DATA_OUT(DATA_O),
    .SELECT_SB_OR_CLUSTER(SEL_O), .DONE(DONE), .ERROR(ERROR)
`ifdef LOADER_CRC_EN
    , .CRC(CRC)
`endif
  );

  cfg_loader_burst #(.NB_ELEM(1)) dut1 (
    .CLK(CLK), .RESET(RESET), .SELECT(SELECT), .VALID(VALID1), .READY(READY1),
    .MODE(MODE), .ADDRESS(ADDRESS), .BURST_LEN(BURST_LEN), .DATA_IN(DATA_IN),
    .CLEAR_ERR(CLEAR_ERR), .ADDRESS_SB_OR_CLUSTER(ADDR1), .DATA_OUT(DATA1),
    .SELECT_SB_OR_CLUSTER(SEL1), .DONE(DONE1), .ERROR(ERROR1)
`ifdef LOADER_CRC_EN
    , .CRC(CRC1)
`endif
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: writes expected per beat, burst progress as plain integers
  typedef struct {
    logic [1:0] sel;
    logic [8:0] addr;
    logic [7:0] data;
    logic       done;
  } exp_t;

  exp_t q[$];
  bit   m_burst = 0;
  bit   m_err   = 0;
  int   m_idx, m_sub, m_left;
  int   m_crc   = 0;

  function automatic int crc_byte(input int c, input int d);
    int r;
    r = (c ^ d) & 8'hFF;
    for (int k = 0; k < 8; k++) r = (r & 8'h80) ? (((r << 1) ^ 8'h07) & 8'hFF) : ((r << 1) & 8'hFF);
    return r;
  endfunction

  task automatic push_write(input int idx, input int sub, input int data, input bit done);
    exp_t e;
    e.sel  = 2'(1 << idx);
    e.addr = 9'(sub);
    e.data = 8'(data);
    e.done = done;
    q.push_back(e);
    m_crc = crc_byte(m_crc, data);
  endtask

  task automatic model_beat(input bit v, input bit s, input bit mode, input int addr,
                            input int len, input int data, input bit clr);
    bit set = 0;
    int idx, sub;
    if (v && s && !m_err) begin
      if (!m_burst) begin
        idx = addr / (1 << SUB_W);
        sub = addr % (1 << SUB_W);
        if (mode) m_crc = 0;
        if (idx >= NB) set = 1;
        else begin
          push_write(idx, sub, data, mode && (len == 0));
          if (mode && len > 0) begin
            m_burst = 1; m_idx = idx; m_sub = sub + 1; m_left = len;
          end
        end
      end else begin
        if (m_sub > (1 << SUB_W) - 1) begin
          set = 1; m_burst = 0;
        end else begin
          push_write(m_idx, m_sub, data, m_left == 1);
          m_sub++; m_left--;
          if (m_left == 0) m_burst = 0;
        end
      end
    end
    m_err = set | (m_err & !clr);
  endtask

  // Drive one cycle of stimulus, update model, then check handshake flags
  task automatic drive(input bit v, input bit s, input bit mode, input logic [9:0] addr,
                       input logic [7:0] len, input logic [7:0] data, input bit clr);
    VALID = v; SELECT = s; MODE = mode; ADDRESS = addr; BURST_LEN = len;
    DATA_IN = data; CLEAR_ERR = clr;
    model_beat(v, s, mode, int'(addr), int'(len), int'(data), clr);
    @(posedge CLK); #1;
    check("error", 32'(ERROR), 32'(m_err));
    check("ready", 32'(READY), 32'(!m_err));
`ifdef LOADER_CRC_EN
    check("crc", 32'(CRC), 32'(m_crc));
`endif
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, '0, '0, '0, 0);
  endtask

  // Monitor: every strobe or DONE must match the oldest expected write
  always @(negedge CLK) begin
    if (RESET && (SEL_O != '0 || DONE)) begin
      if (q.size() == 0) begin
        check("unexpected_strobe", {30'b0, SEL_O}, 32'h0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("strobe", 32'(SEL_O), 32'(e.sel));
        check("sub_addr", 32'(ADDR_O), 32'(e.addr));
        check("data", 32'(DATA_O), 32'(e.data));
        check("done", 32'(DONE), 32'(e.done));
      end
    end
  end

  task automatic apply_reset_now();
    @(negedge CLK); #2;
    RESET = 1'b0; #1;
    check("rst_sel", 32'(SEL_O), 32'h0);
    check("rst_addr", 32'(ADDR_O), 32'h0);
    check("rst_data", 32'(DATA_O), 32'h0);
    check("rst_done", 32'(DONE), 32'h0);
    check("rst_error", 32'(ERROR), 32'h0);
    check("rst_queue_drained", 32'(q.size()), 32'h0);
    q.delete();
    m_burst = 0; m_err = 0; m_crc = 0;
    VALID = 0; VALID1 = 0; SELECT = 0; CLEAR_ERR = 0;
    @(posedge CLK); #2;
    RESET = 1'b1;
    @(posedge CLK); #1;
    check("ready_after_reset", 32'(READY), 32'h1);
  endtask

  initial begin
    // Power-on reset
    repeat (2) @(posedge CLK);
    #1;
    check("por_sel", 32'(SEL_O), 32'h0);
    check("por_error", 32'(ERROR), 32'h0);
    RESET = 1'b1;
    @(posedge CLK); #1;
    check("por_ready", 32'(READY), 32'h1);

    // Invalid index on the one-element instance
    SELECT = 1; MODE = 0; ADDRESS = 10'h300; DATA_IN = 8'h5A; VALID1 = 1;
    @(posedge CLK); #1;
    check("inv_no_strobe", 32'(SEL1), 32'h0);
    check("inv_error", 32'(ERROR1), 32'h1);
    check("inv_ready", 32'(READY1), 32'h0);
    ADDRESS = 10'h005;
    @(posedge CLK); #1;
    check("inv_ignored_strobe", 32'(SEL1), 32'h0);
    check("inv_ignored_data", 32'(DATA1), 32'h0);
    VALID1 = 0; CLEAR_ERR = 1;
    @(posedge CLK); #1;
    check("inv_cleared", 32'(ERROR1), 32'h0);
    check("inv_ready_back", 32'(READY1), 32'h1);
    CLEAR_ERR = 0; VALID1 = 1; DATA_IN = 8'h77;
    @(posedge CLK); #1;
    check("inv_then_write_sel", 32'(SEL1), 32'h1);
    check("inv_then_write_addr", 32'(ADDR1), 32'h5);
    check("inv_then_write_data", 32'(DATA1), 32'h77);
    VALID1 = 0; SELECT = 0;
    @(posedge CLK); #1;

    // Single write
    drive(1, 1, 0, 10'h205, 8'd0, 8'hA5, 0);
    idle(2);

    // Burst of four beats with gaps
    drive(1, 1, 1, 10'h010, 8'd3, 8'h11, 0);
    drive(0, 1, 0, 10'h3FF, 8'd9, 8'hFF, 0);
    drive(1, 1, 0, 10'h3AB, 8'd7, 8'h12, 0);
    drive(1, 0, 1, 10'h000, 8'd0, 8'hEE, 0);
    drive(1, 1, 1, 10'h155, 8'd0, 8'h13, 0);
    drive(1, 1, 0, 10'h000, 8'd0, 8'h14, 0);
    drive(1, 1, 0, 10'h0AA, 8'd0, 8'h55, 0);
    idle(2);

    // Element-boundary crossing
    drive(1, 1, 1, 10'h1FE, 8'd3, 8'hB0, 0);
    drive(1, 1, 0, 10'h000, 8'd0, 8'hB1, 0);
    drive(1, 1, 0, 10'h000, 8'd0, 8'hB2, 0);
    drive(1, 1, 0, 10'h001, 8'd0, 8'hEE, 0);
    drive(0, 0, 0, 10'h000, 8'd0, 8'h00, 1);
    idle(1);

    // CRC reference burst 0x01,0x02,0x03
    drive(1, 1, 1, 10'h020, 8'd2, 8'h01, 0);
    drive(1, 1, 0, 10'h000, 8'd0, 8'h02, 0);
    drive(1, 1, 0, 10'h000, 8'd0, 8'h03, 0);
`ifdef LOADER_CRC_EN
    check("crc_ref_0x48", 32'(CRC), 32'h48);
`endif
    idle(2);

    // Reset in the middle of a five-beat burst
    drive(1, 1, 1, 10'h040, 8'd4, 8'hC0, 0);
    drive(1, 1, 0, 10'h000, 8'd0, 8'hC1, 0);
    apply_reset_now();
    drive(1, 1, 0, 10'h207, 8'd0, 8'h3C, 0);
    idle(2);

    // Randomised traffic
    for (int n = 0; n < 600; n++) begin
      bit v, s, mode, clr;
      int idx, sub, len;
      v    = ($urandom_range(0, 3) != 0);
      s    = ($urandom_range(0, 7) != 0);
      mode = 1'($urandom_range(0, 1));
      idx  = $urandom_range(0, 1);
      sub  = ($urandom_range(0, 3) == 0) ? $urandom_range(504, 511) : $urandom_range(0, 511);
      len  = ($urandom_range(0, 15) == 0) ? $urandom_range(0, 40) : $urandom_range(0, 4);
      clr  = m_err ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0);
      drive(v, s, mode, 10'(idx * 512 + sub), 8'(len), 8'($urandom_range(0, 255)), clr);
    end
    idle(3);
    check("queue_empty_at_end", 32'(q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

`default_nettype wire
